// File: rtl/mult_seq_shiftadd_if.sv
// Start/ready handshake bundle for mult_seq_shiftadd.
// The tc field is present only when MULT_SEQ_SIGNED_EN is defined.
interface mult_seq_shiftadd_if #(
  parameter int NBITS = 8
);
  logic               start;
  logic [NBITS-1:0]   a_in;
  logic [NBITS-1:0]   b_in;
`ifdef MULT_SEQ_SIGNED_EN
  logic               tc;
`endif
  logic               ready;
  logic               done;
  logic [2*NBITS-1:0] z_out;

  modport master (
    output start,
    output a_in,
    output b_in,
`ifdef MULT_SEQ_SIGNED_EN
    output tc,
`endif
    input  ready,
    input  done,
    input  z_out
  );

  modport slave (
    input  start,
    input  a_in,
    input  b_in,
`ifdef MULT_SEQ_SIGNED_EN
    input  tc,
`endif
    output ready,
    output done,
    output z_out
  );
endinterface

// File: rtl/mult_seq_shiftadd.sv
// Sequential shift-and-add multiplier with early exit on an exhausted multiplier.
// Define MULT_SEQ_SIGNED_EN to add two's-complement operands (tc) and the NEG state.
module mult_seq_shiftadd #(
  parameter int NBITS = 8
) (
  input  logic               clk,
  input  logic               rst_b,
  mult_seq_shiftadd_if.slave bus
);
  localparam int W = 2 * NBITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
`ifdef MULT_SEQ_SIGNED_EN
    ,
    NEG  = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [NBITS-1:0] b_q, b_d;
  logic [W-1:0]     z_q, z_d;
  logic             done_q, done_d;
  logic [NBITS-1:0] a_mag, b_mag;
  logic [NBITS-1:0] b_shift;
`ifdef MULT_SEQ_SIGNED_EN
  logic             neg_q, neg_d;
  logic             neg_in;

  // Magnitudes; the most negative value maps onto 2^(NBITS-1), which still fits unsigned.
  always_comb begin
    a_mag  = (bus.tc && bus.a_in[NBITS-1]) ? (~bus.a_in + 1'b1) : bus.a_in;
    b_mag  = (bus.tc && bus.b_in[NBITS-1]) ? (~bus.b_in + 1'b1) : bus.b_in;
    neg_in = bus.tc & (bus.a_in[NBITS-1] ^ bus.b_in[NBITS-1]);
  end
`else
  always_comb begin
    a_mag = bus.a_in;
    b_mag = bus.b_in;
  end
`endif

  assign b_shift = b_q >> 1;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    done_d  = 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          z_d = '0;
          if ((bus.a_in == '0) || (bus.b_in == '0)) begin
            done_d = 1'b1;
          end else begin
            a_d     = {{NBITS{1'b0}}, a_mag};
            b_d     = b_mag;
            state_d = RUN;
`ifdef MULT_SEQ_SIGNED_EN
            neg_d   = neg_in;
`endif
          end
        end
      end
      RUN: begin
        if (b_q[0]) begin
          z_d = z_q + a_q;
        end
        a_d = a_q << 1;
        b_d = b_shift;
        // Leave as soon as no multiplier bits remain.
        if (b_shift == '0) begin
`ifdef MULT_SEQ_SIGNED_EN
          if (neg_q) begin
            state_d = NEG;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef MULT_SEQ_SIGNED_EN
      NEG: begin
        z_d     = ~z_q + 1'b1;
        state_d = IDLE;
        done_d  = 1'b1;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      done_q  <= 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      done_q  <= done_d;
`ifdef MULT_SEQ_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.done  = done_q;
  assign bus.z_out = z_q;
endmodule
